mux_4x1: RTL and testbench

MUX_4X1 -- requirements
Module: mux_4x1

---
 rtl/mux_4x1.sv | 45 ++++
 tb/tb_mux_4x1.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mux_4x1.sv
// 4:1 single-bit mux built from delayed gate primitives, with a registered copy of the
// selected bit and a valid flag that rises on the first capture after reset.
`timescale 10ps/1ps

module mux_4x1 #(
    parameter int unsigned GATE_DELAY = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] in,
    input  logic [1:0] sel,
    output logic       out,
    output logic       out_q,
    output logic       out_valid
);

    wire [1:0] sel_n;
    wire [3:0] term;
    wire       out_comb;

    not #(GATE_DELAY) u_inv_sel0 (sel_n[0], sel[0]);
    not #(GATE_DELAY) u_inv_sel1 (sel_n[1], sel[1]);

    // One AND term per data bit: with sel stable only the selected term can move, so an
    // unselected in bit (even X) is masked by a 0 on the decode inputs and cannot glitch out.
    and #(GATE_DELAY) u_and_term0 (term[0], in[0], sel_n[1], sel_n[0]);
    and #(GATE_DELAY) u_and_term1 (term[1], in[1], sel_n[1], sel[0]);
    and #(GATE_DELAY) u_and_term2 (term[2], in[2], sel[1],   sel_n[0]);
    and #(GATE_DELAY) u_and_term3 (term[3], in[3], sel[1],   sel[0]);

    or  #(GATE_DELAY) u_or_out (out_comb, term[0], term[1], term[2], term[3]);

    assign out = out_comb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_q     <= out_comb;
            out_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_4x1.sv
// Randomized self-checking bench for mux_4x1 against a bit-select reference model.
`timescale 10ps/1ps

module tb_mux_4x1;

    localparam int unsigned GateDelay = 5;
    localparam int unsigned Settle    = 3 * GateDelay + 1;

    logic       clk;
    logic       reset_n;
    logic [3:0] din;
    logic [1:0] sel;
    logic       dout;
    logic       dout_q;
    logic       dout_valid;

    int n_vec;
    int n_fail;
    int out_changes;

    logic exp_q;
    logic exp_valid;

    mux_4x1 #(.GATE_DELAY(GateDelay)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (din),
        .sel      (sel),
        .out      (dout),
        .out_q    (dout_q),
        .out_valid(dout_valid)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    initial out_changes = 0;
    always @(dout) out_changes = out_changes + 1;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the selected bit is simply din indexed by sel.
    function automatic logic ref_out(input logic [3:0] d, input logic [1:0] s);
        return d[s];
    endfunction

    initial begin
        logic A;
        logic B;
        logic [3:0] alu;
        logic [3:0] xin;
        int base;
        n_vec   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        din     = 4'b0000;
        sel     = 2'd0;
        #20;
        check("reset_out_q", {7'd0, dout_q}, 8'd0);
        check("reset_out_valid", {7'd0, dout_valid}, 8'd0);

        // Exhaustive sweep while in reset: combinational path must stay live.
        for (int d = 0; d < 16; d++) begin
            for (int s = 0; s < 4; s++) begin
                din = d[3:0];
                sel = s[1:0];
                #(Settle);
                check("sweep_out", {7'd0, dout}, {7'd0, ref_out(din, sel)});
            end
        end
        check("sweep_out_q_held", {7'd0, dout_q}, 8'd0);
        check("sweep_valid_held", {7'd0, dout_valid}, 8'd0);

        din = 4'b1010; sel = 2'd1; #(Settle);
        check("ex_1010_s1", {7'd0, dout}, 8'd1);
        sel = 2'd2; #(Settle);
        check("ex_1010_s2", {7'd0, dout}, 8'd0);

        A = 1'b1; B = 1'b0;
        alu = {A ^ B, B, A | B, A & B};
        for (int s = 0; s < 4; s++) begin
            din = alu;
            sel = s[1:0];
            #(Settle);
            check("alu_slice", {7'd0, dout}, {7'd0, ref_out(alu, sel)});
        end

        // Registered path: release away from an edge, then exactly one capture.
        @(negedge clk);
        reset_n = 1'b1;
        din = 4'b1000;
        sel = 2'd3;
        #(Settle);
        check("pre_edge_out_q", {7'd0, dout_q}, 8'd0);
        check("pre_edge_valid", {7'd0, dout_valid}, 8'd0);
        @(posedge clk); #1;
        check("first_cap_out_q", {7'd0, dout_q}, 8'd1);
        check("first_cap_valid", {7'd0, dout_valid}, 8'd1);

        // Asynchronous reset between edges.
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_out_q", {7'd0, dout_q}, 8'd0);
        check("async_rst_valid", {7'd0, dout_valid}, 8'd0);
        check("async_rst_out", {7'd0, dout}, {7'd0, ref_out(din, sel)});

        // X isolation on unselected bits.
        xin = 4'bxx01;
        din = xin; sel = 2'd0; #(Settle);
        check("xiso_s0", {7'd0, dout}, 8'd1);
        check("xiso_s0_known", {7'd0, $isunknown(dout)}, 8'd0);
        sel = 2'd1; #(Settle);
        check("xiso_s1", {7'd0, dout}, 8'd0);
        check("xiso_s1_known", {7'd0, $isunknown(dout)}, 8'd0);

        // Glitch check: sel held at 2, only unselected bits toggle.
        for (int v = 0; v < 2; v++) begin
            sel = 2'd2;
            din = {1'b0, v[0], 2'b00};
            #(Settle);
            base = out_changes;
            for (int k = 0; k < 40; k++) begin
                din[0] = $urandom_range(0, 1);
                din[1] = $urandom_range(0, 1);
                din[3] = $urandom_range(0, 1);
                #($urandom_range(1, 20));
            end
            #(Settle);
            check("glitch_edges", out_changes - base, 8'd0);
            check("glitch_value", {7'd0, dout}, {7'd0, v[0]});
        end

        // Random run with occasional mid-operation resets.
        exp_q = 1'b0;
        exp_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 15) != 0);
            din = $urandom_range(0, 15);
            sel = $urandom_range(0, 3);
            #(Settle);
            check("rand_out", {7'd0, dout}, {7'd0, ref_out(din, sel)});
            if (!reset_n) begin
                exp_q = 1'b0;
                exp_valid = 1'b0;
            end
            check("rand_pre_out_q", {7'd0, dout_q}, {7'd0, exp_q});
            check("rand_pre_valid", {7'd0, dout_valid}, {7'd0, exp_valid});
            @(posedge clk); #1;
            if (reset_n) begin
                exp_q = ref_out(din, sel);
                exp_valid = 1'b1;
            end
            check("rand_out_q", {7'd0, dout_q}, {7'd0, exp_q});
            check("rand_valid", {7'd0, dout_valid}, {7'd0, exp_valid});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
